// File: rtl/uart_alu_engine.sv
// Byte-stream packet ALU between uart_rx and uart_tx: header parse, operand fold, result/echo/error reply.
// Optional feature: define UART_ALU_DIV_EN to add opcode 0x04 (restoring divider, 1 bit/cycle).
module uart_alu_engine #(
  parameter int unsigned OPERAND_BYTES = 4,
  parameter logic [7:0]  ERR_BYTE      = 8'hEE,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned W  = 8 * OPERAND_BYTES;
  localparam int unsigned BW = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_ECHO = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;

  typedef enum logic [3:0] {
    S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_EXEC, S_RESP, S_DRAIN, S_ERR
  } state_t;

  state_t               state, state_n;
  logic                 run;
  logic [15:0]          cnt, cnt_n;
  logic [7:0]           opc, opc_n;
  logic [7:0]           len_lo, len_lo_n;
  logic [W-1:0]         acc, acc_n;
  logic [W-1:0]         opnd, opnd_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [7:0]           data_n;
  logic                 valid_n;
  logic [ERR_CNT_W-1:0] err_cnt, err_n;
`ifdef UART_ALU_DIV_EN
  logic [1:0]           nops, nops_n;
  logic [W-1:0]         dvsr, dvsr_n;
  logic [W-1:0]         rem, rem_n;
  logic [W:0]           rem_sh;
  logic [W-1:0]         rem_step, q_step;
`endif

  logic         rdy, take, out_take;
  logic         is_add, is_mul, is_echo, is_div, is_alu;
  logic [15:0]  len, plen;
  logic [W-1:0] ident, op_cur, res_val;
  logic         load_res, load_err;

  assign is_add  = (opc == OP_ADD);
  assign is_mul  = (opc == OP_MUL);
  assign is_echo = (opc == OP_ECHO);
`ifdef UART_ALU_DIV_EN
  assign is_div  = (opc == OP_DIV);
`else
  assign is_div  = 1'b0;
`endif
  assign is_alu  = is_add | is_mul | is_div;

  assign len      = {data_i, len_lo};
  assign plen     = len - 16'd4;
  assign op_cur   = opnd | (W'(data_i) << {bidx, 3'b000});
  assign ident    = is_mul ? W'(1) : (is_div ? '1 : '0);
  assign take     = valid_i && rdy;
  assign out_take = valid_o && ready_i;

  assign ready_o   = rdy;
  assign busy_o    = (state != S_OPCODE);
  assign err_cnt_o = err_cnt;

  // ECHO passes uart_tx backpressure straight through to uart_rx.
  always_comb begin
    rdy = 1'b0;
    case (state)
      S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_DRAIN: rdy = run;
      S_PAYLOAD: rdy = is_echo ? (ready_i && cnt != '0) : 1'b1;
      default:   rdy = 1'b0;
    endcase
  end

`ifdef UART_ALU_DIV_EN
  always_comb begin
    rem_sh = {rem, acc[W-1]};
    if (rem_sh >= {1'b0, dvsr}) begin
      rem_step = W'(rem_sh - {1'b0, dvsr});
      q_step   = {acc[W-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[W-1:0];
      q_step   = {acc[W-2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    opc_n    = opc;
    len_lo_n = len_lo;
    acc_n    = acc;
    opnd_n   = opnd;
    bidx_n   = bidx;
    data_n   = data_o;
    valid_n  = valid_o;
    err_n    = err_cnt;
    load_res = 1'b0;
    load_err = 1'b0;
    res_val  = '0;
`ifdef UART_ALU_DIV_EN
    nops_n   = nops;
    dvsr_n   = dvsr;
    rem_n    = rem;
`endif
    unique case (state)
      S_OPCODE: if (take) begin opc_n = data_i; state_n = S_RSV; end
      S_RSV:    if (take) state_n = S_LEN_LO;
      S_LEN_LO: if (take) begin len_lo_n = data_i; state_n = S_LEN_HI; end
      S_LEN_HI: if (take) begin
        if (len < 16'd4) begin
          load_err = 1'b1;
        end else if (is_echo) begin
          cnt_n   = plen;
          state_n = (len == 16'd4) ? S_OPCODE : S_PAYLOAD;
        end else if (is_alu) begin
          acc_n  = ident;
          opnd_n = '0;
          bidx_n = '0;
`ifdef UART_ALU_DIV_EN
          nops_n = 2'd0;
          dvsr_n = '0;
`endif
          if (len == 16'd4) begin
            load_res = 1'b1;
            res_val  = ident;
          end else begin
            cnt_n   = plen;
            state_n = S_PAYLOAD;
          end
        end else if (len == 16'd4) begin
          load_err = 1'b1;
        end else begin
          cnt_n   = plen;
          state_n = S_DRAIN;
        end
      end
      S_PAYLOAD: begin
        if (is_echo) begin
          if (take) begin
            data_n  = data_i;
            valid_n = 1'b1;
            cnt_n   = cnt - 16'd1;
          end else if (out_take) begin
            valid_n = 1'b0;
          end
          if (cnt == '0 && out_take) begin
            valid_n = 1'b0;
            state_n = S_OPCODE;
          end
        end else if (take) begin
          cnt_n = cnt - 16'd1;
          // A full operand or the last payload byte (zero-extended partial) folds into acc.
          if (bidx == BW'(OPERAND_BYTES - 1) || cnt == 16'd1) begin
            opnd_n = '0;
            bidx_n = '0;
            if (is_add) acc_n = acc + op_cur;
            else if (is_mul) acc_n = acc * op_cur;
`ifdef UART_ALU_DIV_EN
            else begin
              if (nops == 2'd0) acc_n = op_cur;
              if (nops == 2'd1) dvsr_n = op_cur;
              if (nops != 2'd2) nops_n = nops + 2'd1;
            end
`endif
          end else begin
            opnd_n = op_cur;
            bidx_n = bidx + BW'(1);
          end
          if (cnt == 16'd1) begin
            if (is_div) begin
              state_n = S_EXEC;
              cnt_n   = 16'(W - 1);
`ifdef UART_ALU_DIV_EN
              rem_n   = '0;
`endif
            end else begin
              load_res = 1'b1;
              res_val  = acc_n;
            end
          end
        end
      end
      S_EXEC: begin
`ifdef UART_ALU_DIV_EN
        acc_n = q_step;
        rem_n = rem_step;
        cnt_n = cnt - 16'd1;
        if (cnt == '0) begin
          load_res = 1'b1;
          res_val  = q_step;
        end
`else
        state_n = S_OPCODE;
`endif
      end
      S_RESP: if (out_take) begin
        if (cnt == '0) begin
          valid_n = 1'b0;
          state_n = S_OPCODE;
        end else begin
          data_n = acc[7:0];
          acc_n  = acc >> 8;
          cnt_n  = cnt - 16'd1;
        end
      end
      S_DRAIN: if (take) begin
        cnt_n = cnt - 16'd1;
        if (cnt == 16'd1) load_err = 1'b1;
      end
      S_ERR: if (out_take) begin
        valid_n = 1'b0;
        state_n = S_OPCODE;
        err_n   = (err_cnt == '1) ? err_cnt : err_cnt + ERR_CNT_W'(1);
      end
      default: state_n = S_OPCODE;
    endcase
    if (load_res) begin
      data_n  = res_val[7:0];
      acc_n   = res_val >> 8;
      cnt_n   = 16'(OPERAND_BYTES - 1);
      valid_n = 1'b1;
      state_n = S_RESP;
    end
    if (load_err) begin
      data_n  = ERR_BYTE;
      valid_n = 1'b1;
      state_n = S_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_OPCODE;
      run     <= 1'b0;
      cnt     <= '0;
      opc     <= '0;
      len_lo  <= '0;
      acc     <= '0;
      opnd    <= '0;
      bidx    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      err_cnt <= '0;
`ifdef UART_ALU_DIV_EN
      nops    <= '0;
      dvsr    <= '0;
      rem     <= '0;
`endif
    end else begin
      state   <= state_n;
      run     <= 1'b1;
      cnt     <= cnt_n;
      opc     <= opc_n;
      len_lo  <= len_lo_n;
      acc     <= acc_n;
      opnd    <= opnd_n;
      bidx    <= bidx_n;
      data_o  <= data_n;
      valid_o <= valid_n;
      err_cnt <= err_n;
`ifdef UART_ALU_DIV_EN
      nops    <= nops_n;
      dvsr    <= dvsr_n;
      rem     <= rem_n;
`endif
    end
  end

endmodule
